// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared constants and types for the RV32I load path.
//   - OPC_LOAD           : major opcode for all integer loads
//   - F3_*               : funct3 encodings of the five legal load widths
//   - ld_state_t         : load_sequencer FSM states
//   - f3_is_legal()      : true for the five legal load funct3 values
//   - f3_last_byte()     : index of the final byte lane for a load width
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    REQ   = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  function automatic logic f3_is_legal(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Byte lanes are filled 0..N-1; this returns N-1 for the access width.
  function automatic logic [1:0] f3_last_byte(input logic [2:0] f3);
    logic [1:0] last;
    case (f3)
      F3_LH, F3_LHU: last = 2'd1;
      F3_LW:         last = 2'd3;
      default:       last = 2'd0;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational width/sign adjustment of an assembled little-endian load.
//   Ports:
//     funct3  in   3     load width/sign selector (LB/LH/LW/LBU/LHU)
//     raw     in   32    assembled bytes, lane 0 in raw[7:0]
//     data    out  XLEN  sign- or zero-extended result
// ---------------------------------------------------------------------------
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [31:0]     raw,
  output logic [XLEN-1:0] data
);

  // A size cast of a signed operand sign-extends; of an unsigned one, zero-extends.
  always_comb begin
    data = '0;
    case (funct3)
      F3_LB:   data = XLEN'($signed(raw[7:0]));
      F3_LH:   data = XLEN'($signed(raw[15:0]));
      F3_LW:   data = XLEN'($signed(raw));
      F3_LBU:  data = XLEN'(raw[7:0]);
      F3_LHU:  data = XLEN'(raw[15:0]);
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/load_sequencer.sv
// ---------------------------------------------------------------------------
// load_sequencer
//   Multi-cycle RV32I load controller over a byte-wide memory port.
//   Accepts a decoded load, validates opcode/funct3/alignment, issues 1/2/4
//   little-endian byte reads, then presents an extended result for write-back.
//   Ports:
//     clk, rst              clock / synchronous active-high reset
//     ld_valid, ld_ready    core-side request handshake (ready only in IDLE)
//     op_code, funct3,
//     addr, rd              request fields, sampled on the accept cycle only
//     mem_req, mem_addr     byte read request, held until mem_ack
//     mem_ack, mem_rdata    read byte return
//     wb_valid              one-cycle write-back strobe
//     wb_rd, wb_data        write-back target/value, held until next DONE
//     wb_err                failed request (wb_data=0), with wb_valid
// ---------------------------------------------------------------------------
module load_sequencer
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [6:0]        op_code,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [4:0]        rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_err
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  ld_state_t         state_q, state_d;
  logic [6:0]        op_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;     // doubles as the running byte address
  logic [4:0]        rd_q;
  logic [1:0]        idx_q;      // byte lane being fetched
  logic [CNT_W-1:0]  wait_q;     // cycles spent waiting on the current byte
  logic [31:0]       raw_q, raw_d;
  logic [XLEN-1:0]   wb_data_q;
  logic [4:0]        wb_rd_q;
  logic              wb_err_q;

  logic              check_err;
  logic              misaligned;
  logic              last_byte;
  logic              timed_out;
  logic [XLEN-1:0]   ext_data;

  // Validation runs on the latched request so later input changes cannot leak in.
  always_comb begin
    misaligned = 1'b0;
    if ((f3_q == F3_LH || f3_q == F3_LHU) && addr_q[0])
      misaligned = 1'b1;
    if (f3_q == F3_LW && addr_q[1:0] != 2'b00)
      misaligned = 1'b1;
  end

  assign check_err = (op_q != OPC_LOAD) || !f3_is_legal(f3_q) || misaligned;
  assign last_byte = (idx_q == f3_last_byte(f3_q));
  assign timed_out = !mem_ack && (wait_q == WAIT_LAST);

  // Merge the arriving byte into its lane; the extender sees the completed
  // word in the same cycle the final byte is acknowledged.
  always_comb begin
    raw_d = raw_q;
    if (state_q == REQ && mem_ack)
      raw_d[{idx_q, 3'b000} +: 8] = mem_rdata;
  end

  load_extend #(
    .XLEN (XLEN)
  ) u_extend (
    .funct3 (f3_q),
    .raw    (raw_d),
    .data   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ld_valid) state_d = CHECK;
      CHECK: state_d = check_err ? DONE : REQ;
      REQ: begin
        if (mem_ack && last_byte) state_d = DONE;
        else if (timed_out)       state_d = DONE;
      end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      f3_q      <= '0;
      addr_q    <= '0;
      rd_q      <= '0;
      idx_q     <= '0;
      wait_q    <= '0;
      raw_q     <= '0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
      wb_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (ld_valid) begin
            op_q   <= op_code;
            f3_q   <= funct3;
            addr_q <= addr;
            rd_q   <= rd;
            idx_q  <= '0;
            wait_q <= '0;
            raw_q  <= '0;
          end
        end
        CHECK: begin
          if (check_err) begin
            wb_data_q <= '0;
            wb_rd_q   <= rd_q;
            wb_err_q  <= 1'b1;
          end
        end
        REQ: begin
          raw_q <= raw_d;
          if (mem_ack) begin
            wait_q <= '0;
            idx_q  <= idx_q + 2'd1;
            if (last_byte) begin
              wb_data_q <= ext_data;
              wb_rd_q   <= rd_q;
              wb_err_q  <= 1'b0;
            end else begin
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else if (timed_out) begin
            wb_data_q <= '0;
            wb_rd_q   <= rd_q;
            wb_err_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign ld_ready = (state_q == IDLE);
  assign mem_req  = (state_q == REQ);
  assign mem_addr = addr_q;
  assign wb_valid = (state_q == DONE);
  assign wb_rd    = wb_rd_q;
  assign wb_data  = wb_data_q;
  assign wb_err   = wb_err_q && (state_q == DONE);

endmodule

// File: tb/tb_load_sequencer.sv
module tb_load_sequencer;

  logic        clk;
  logic        rst;
  logic        ld_valid;
  logic        ld_ready;
  logic [6:0]  op_code;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [4:0]  rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_err;

  int errors = 0;
  int checks = 0;

  // memory responder controls and observations
  int          ack_dly;
  logic        ack_off;
  logic        force_ack;
  int          req_cycles;
  logic [31:0] acked_addrs[$];
  logic [7:0]  mem [logic [31:0]];

  load_sequencer #(
    .XLEN(32), .ADDR_W(32), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .op_code(op_code), .funct3(funct3), .addr(addr), .rd(rd),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Byte memory: drives on the falling edge so values are stable at posedge.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'hA5;
      end else if (mem_req) begin
        req_cycles++;
        if (!ack_off && wait_cnt >= ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_byte(mem_addr);
          acked_addrs.push_back(mem_addr);
          wait_cnt  = 0;
        end else begin
          mem_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle (cycle T), then wait for wb_valid.
  // lat is the number of cycles from T to the wb_valid cycle.
  task automatic do_load(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [4:0] r,
                         output int lat);
    req_cycles = 0;
    acked_addrs.delete();
    chk("accept_ready", ld_ready, 1'b1);
    ld_valid = 1'b1; op_code = opc; funct3 = f3; addr = a; rd = r;
    step();
    // junk on the request fields must be ignored after acceptance
    ld_valid = 1'b0; op_code = 7'h7F; funct3 = 3'b111; addr = 32'hDEADBEEF; rd = 5'h1F;
    chk("busy_ready", ld_ready, 1'b0);
    lat = 1;
    while (!wb_valid && lat < 60) begin
      step();
      lat++;
    end
    chk("wb_seen", wb_valid, 1'b1);
    $display("load op=%b f3=%b addr=%h rd=%0d -> lat=%0d data=%h err=%b rd=%0d reqs=%0d",
             opc, f3, a, r, lat, wb_data, wb_err, wb_rd, req_cycles);
  endtask

  initial begin
    int lat;
    mem[32'h100] = 8'h80; mem[32'h101] = 8'h7F; mem[32'h102] = 8'h34; mem[32'h103] = 8'h92;
    mem[32'h200] = 8'h78; mem[32'h201] = 8'h56; mem[32'h202] = 8'h34; mem[32'h203] = 8'h12;
    mem[32'h400] = 8'hFF;
    ack_dly = 0; ack_off = 1'b0; force_ack = 1'b0; req_cycles = 0;
    rst = 1'b1; ld_valid = 1'b0; op_code = '0; funct3 = '0; addr = '0; rd = '0;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    chk("rst_ready", ld_ready, 1'b1);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_wbrd", wb_rd, 5'd0);
    chk("rst_wbdata", wb_data, 32'h0);
    chk("rst_wberr", wb_err, 1'b0);

    // stale ack in IDLE is ignored
    force_ack = 1'b1; step(); step(); force_ack = 1'b0; step();
    chk("stale_ready", ld_ready, 1'b1);
    chk("stale_req", mem_req, 1'b0);
    chk("stale_wbv", wb_valid, 1'b0);

    // LB 0x100 = 0x80, immediate ack
    do_load(7'b0000011, 3'b000, 32'h100, 5'd5, lat);
    chk("lb_lat", lat, 3);
    chk("lb_data", wb_data, 32'hFFFFFF80);
    chk("lb_err", wb_err, 1'b0);
    chk("lb_rd", wb_rd, 5'd5);
    chk("lb_reqs", req_cycles, 1);
    chk("lb_addr0", acked_addrs.size() > 0 ? acked_addrs[0] : 32'hX, 32'h100);
    step();
    chk("lb_pulse", wb_valid, 1'b0);
    chk("lb_idle", ld_ready, 1'b1);
    chk("lb_hold", wb_data, 32'hFFFFFF80);

    // LW 0x200 with 2-cycle ack delay per byte
    ack_dly = 2;
    do_load(7'b0000011, 3'b010, 32'h200, 5'd9, lat);
    chk("lw_lat", lat, 14);
    chk("lw_data", wb_data, 32'h12345678);
    chk("lw_err", wb_err, 1'b0);
    chk("lw_nbytes", acked_addrs.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("lw_addr%0d", i), acked_addrs.size() > i ? acked_addrs[i] : 32'hX, 32'h200 + i);
    step();
    ack_dly = 0;

    // LHU misaligned
    do_load(7'b0000011, 3'b101, 32'h301, 5'd2, lat);
    chk("lhu_mis_lat", lat, 2);
    chk("lhu_mis_err", wb_err, 1'b1);
    chk("lhu_mis_data", wb_data, 32'h0);
    chk("lhu_mis_reqs", req_cycles, 0);
    step();
    chk("err_pulse", wb_err, 1'b0);

    // bad opcode
    do_load(7'b0000001, 3'b010, 32'h200, 5'd3, lat);
    chk("badop_lat", lat, 2);
    chk("badop_err", wb_err, 1'b1);
    chk("badop_reqs", req_cycles, 0);
    step();

    // illegal funct3 and misaligned LW
    do_load(7'b0000011, 3'b011, 32'h200, 5'd3, lat);
    chk("badf3_err", wb_err, 1'b1);
    step();
    do_load(7'b0000011, 3'b010, 32'h202, 5'd3, lat);
    chk("lw_mis_err", wb_err, 1'b1);
    chk("lw_mis_reqs", req_cycles, 0);
    step();

    // sign/zero extension of halfwords and a positive byte
    do_load(7'b0000011, 3'b001, 32'h102, 5'd4, lat);
    chk("lh_lat", lat, 4);
    chk("lh_data", wb_data, 32'hFFFF9234);
    step();
    do_load(7'b0000011, 3'b101, 32'h102, 5'd4, lat);
    chk("lhu_data", wb_data, 32'h00009234);
    step();
    do_load(7'b0000011, 3'b000, 32'h101, 5'd0, lat);
    chk("lb_pos_data", wb_data, 32'h0000007F);
    chk("rd0_rd", wb_rd, 5'd0);
    step();

    // timeout: no ack at all
    ack_off = 1'b1;
    do_load(7'b0000011, 3'b001, 32'h10, 5'd6, lat);
    chk("to_lat", lat, 18);
    chk("to_err", wb_err, 1'b1);
    chk("to_data", wb_data, 32'h0);
    chk("to_reqs", req_cycles, 16);
    step();
    chk("to_req_low", mem_req, 1'b0);
    ack_off = 1'b0;

    // reset during second byte of LW
    req_cycles = 0;
    ld_valid = 1'b1; op_code = 7'b0000011; funct3 = 3'b010; addr = 32'h200; rd = 5'd8;
    step();
    ld_valid = 1'b0;
    step();             // T+2: byte 0
    step();             // T+3: byte 1
    chk("mid_req", mem_req, 1'b1);
    chk("mid_addr", mem_addr, 32'h201);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_req", mem_req, 1'b0);
    chk("mrst_ready", ld_ready, 1'b1);
    chk("mrst_wbv", wb_valid, 1'b0);
    chk("mrst_data", wb_data, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mrst_no_wb", wb_valid, 1'b0);
    end
    do_load(7'b0000011, 3'b100, 32'h400, 5'd7, lat);
    chk("lbu_lat", lat, 3);
    chk("lbu_data", wb_data, 32'h000000FF);
    chk("lbu_rd", wb_rd, 5'd7);
    step();

    // back-to-back with ld_valid held high
    ld_valid = 1'b1; op_code = 7'b0000011; funct3 = 3'b000; addr = 32'h100; rd = 5'd3;
    step();             // T+1
    op_code = 7'b0000011; funct3 = 3'b100; addr = 32'h100; rd = 5'd4;
    chk("b2b_ready1", ld_ready, 1'b0);
    step();             // T+2
    chk("b2b_ready2", ld_ready, 1'b0);
    step();             // T+3
    chk("b2b_wbv1", wb_valid, 1'b1);
    chk("b2b_data1", wb_data, 32'hFFFFFF80);
    chk("b2b_rd1", wb_rd, 5'd3);
    chk("b2b_ready3", ld_ready, 1'b0);
    $display("b2b first: data=%h rd=%0d", wb_data, wb_rd);
    step();             // T+4: second accept
    chk("b2b_ready4", ld_ready, 1'b1);
    chk("b2b_wbv_off", wb_valid, 1'b0);
    step();             // T+5
    ld_valid = 1'b0;
    step();             // T+6
    step();             // T+7
    chk("b2b_wbv2", wb_valid, 1'b1);
    chk("b2b_data2", wb_data, 32'h00000080);
    chk("b2b_rd2", wb_rd, 5'd4);
    $display("b2b second: data=%h rd=%0d", wb_data, wb_rd);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
